// File: rtl/data_memory_pkg.sv
// Shared defaults for the data memory: word width, word-address width and depth.
// Optional feature macro: DATA_MEMORY_RESET_CLEAR_EN (reset clears every word).
package data_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Purpose: word-addressed single-port data memory, combinational read and clocked write.
// Latency: read 0 cycles (readData = mem[address]); write lands on the rising clk edge.
// Backpressure: none; one write accepted per edge, rst blocks the write on that edge.
// DATA_MEMORY_RESET_CLEAR_EN defined: rst zeroes every word; undefined: rst only blocks writes.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] readData
);

  localparam int MemDepth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MemDepth];

`ifdef DATA_MEMORY_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MemDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEnable) begin
      mem[address] <= writeData;
    end
  end
`else
  // Contents survive reset so the array can map onto plain block RAM.
  always_ff @(posedge clk) begin
    if (!rst && writeEnable) begin
      mem[address] <= writeData;
    end
  end
`endif

  assign readData = mem[address];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read values, a negedge monitor compares.
// Reference model is an associative array of written words; reset semantics follow DATA_MEMORY_RESET_CLEAR_EN.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  address = '0;
  logic [31:0] writeData = '0;
  logic        writeEnable = 1'b0;
  logic [31:0] readData;

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .writeData  (writeData),
    .writeEnable(writeEnable),
    .readData   (readData)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } chk_t;

  chk_t        sbQ[$];
  logic        chkVld = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  // Reference model: words written since the last clearing reset; "cleared" means unwritten words are 0.
  logic [31:0] model [int];
  bit          cleared = 1'b0;

  function automatic bit known(input int a);
    return model.exists(a) || cleared;
  endfunction

  function automatic logic [31:0] modelRead(input int a);
    if (model.exists(a)) return model[a];
    return 32'h0;
  endfunction

  // One clock cycle: drive inputs just after an edge, record the value readData must show
  // before the next edge, then advance the model across that edge.
  task automatic cyc(input logic r, input logic we, input logic [7:0] a,
                     input logic [31:0] d, input string nm);
    @(posedge clk);
    #1;
    rst         = r;
    writeEnable = we;
    address     = a;
    writeData   = d;
    if (known(int'(a))) begin
      chk_t c;
      c.nm  = nm;
      c.exp = modelRead(int'(a));
      sbQ.push_back(c);
      chkVld = 1'b1;
    end else begin
      chkVld = 1'b0;
    end
    if (r) begin
`ifdef DATA_MEMORY_RESET_CLEAR_EN
      model.delete();
      cleared = 1'b1;
`endif
    end else if (we) begin
      model[int'(a)] = d;
    end
  endtask

  // Monitor: readData is combinational, so it is "presented" whenever the stimulus flagged a check.
  initial begin
    forever begin
      @(negedge clk);
      if (chkVld) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard_underflow: readData=%h with no expected entry", readData);
        end else begin
          chk_t c;
          c = sbQ.pop_front();
          if (readData !== c.exp) begin
            mismatched++;
            $display("FAIL %s: addr=%0d readData=%h expected=%h", c.nm, address, readData, c.exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b1, 1'b0, 8'd0, 32'h0, "reset_init");
    cyc(1'b0, 1'b0, 8'd0, 32'h0, "reset_state_a0");
    cyc(1'b0, 1'b0, 8'd255, 32'h0, "reset_state_a255");

    // Reset clears (or retains) all-ones at both ends of the array.
    cyc(1'b0, 1'b1, 8'd0,   32'hFFFFFFFF, "rst_wr0");
    cyc(1'b0, 1'b1, 8'd255, 32'hFFFFFFFF, "rst_wr255");
    cyc(1'b0, 1'b0, 8'd0,   32'h0, "rst_pre_a0");
    cyc(1'b1, 1'b0, 8'd0,   32'h0, "rst_pulse");
    cyc(1'b0, 1'b0, 8'd0,   32'h0, "rst_post_a0");
    cyc(1'b0, 1'b0, 8'd255, 32'h0, "rst_post_a255");

    // Back-to-back writes, last wins.
    cyc(1'b0, 1'b1, 8'd0, 32'hAABBCCDD, "wr_first");
    cyc(1'b0, 1'b1, 8'd0, 32'h11223344, "wr_second");
    cyc(1'b0, 1'b0, 8'd0, 32'h0, "wr_readback");

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 32'hDEADBEEF, "no_write_hold");
    end

    // Reset priority over a simultaneous write.
    cyc(1'b0, 1'b1, 8'd3, 32'hCAFE0003, "prio_seed");
    cyc(1'b1, 1'b1, 8'd3, 32'h12345678, "prio_rst_wr");
    cyc(1'b0, 1'b0, 8'd3, 32'h0, "prio_read3");

    // Boundary addresses and isolation of a neighbour.
    cyc(1'b0, 1'b1, 8'd1,   32'h01010101, "iso_seed1");
    cyc(1'b0, 1'b1, 8'd255, 32'hA5A5A5A5, "bnd_wr255");
    cyc(1'b0, 1'b1, 8'd0,   32'h5A5A5A5A, "bnd_wr0");
    cyc(1'b0, 1'b0, 8'd255, 32'h0, "bnd_read255");
    cyc(1'b0, 1'b0, 8'd0,   32'h0, "bnd_read0");
    cyc(1'b0, 1'b0, 8'd1,   32'h0, "iso_read1");

    // Read-during-write: old value before the edge, new value after.
    cyc(1'b0, 1'b1, 8'd7, 32'h1, "rdw_seed");
    cyc(1'b0, 1'b1, 8'd7, 32'h2, "rdw_before_edge");
    cyc(1'b0, 1'b0, 8'd7, 32'h0, "rdw_after_edge");

    // Random traffic concentrated on a few addresses so reads hit written words.
    for (int i = 0; i < 600; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic        we;
      logic        r;
      case ($urandom_range(0, 3))
        0:       a = 8'd0;
        1:       a = 8'd255;
        default: a = 8'($urandom_range(0, 15));
      endcase
      d  = $urandom;
      we = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 39) == 0);
      cyc(r, we, a, d, "random");
    end

    @(posedge clk);
    #1;
    chkVld      = 1'b0;
    writeEnable = 1'b0;
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_leftover: pending=%0d expected=0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_data_memory

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, word-address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide address  input  ADDR_WIDTH  word index, not byte address.
REQ-006 SHALL provide writeData  input  DATA_WIDTH  data to store.
REQ-007 SHALL provide writeEnable  input  1  write strobe, active-high.
REQ-008 SHALL provide readData  output  DATA_WIDTH  word at address.

Function
REQ-009 SHALL hold 2**ADDR_WIDTH words of DATA_WIDTH bits each.
REQ-010 SHALL read combinationally: readData = mem[address], zero-cycle latency, no read enable.
REQ-011 SHALL write writeData into mem[address] on rising clk when writeEnable=1 and rst=0.
REQ-012 SHALL leave all words unchanged on any edge with writeEnable=0.
REQ-013 SHALL return the old word on readData before the write edge, and the new word immediately after it (read-during-write = write-after-edge, no bypass).
REQ-014 SHALL let the last of back-to-back writes to the same address win, one write per edge.
REQ-015 SHALL accept every address value 0 .. 2**ADDR_WIDTH-1 with no wrap-around or out-of-range case.
REQ-016 SHALL ignore writeData and address changes between edges for storage purposes.

Reset
REQ-017 SHALL give rst priority over writeEnable; a write asserted together with rst is discarded.
REQ-018 SHALL, with DATA_MEMORY_RESET_CLEAR_EN defined, set every word to 0 on a rising edge with rst=1, so readData = 0 for any address after reset.
REQ-019 SHALL apply reset mid-operation on the next edge; no partial or pending write survives.
REQ-020 SHALL have no registered outputs; readData reset value follows the memory contents (0 under REQ-018).

Configuration
REQ-021 SHALL use macro DATA_MEMORY_RESET_CLEAR_EN: defined -> reset clears all words (REQ-018); undefined -> reset only blocks writes (REQ-017), contents are retained, and uninitialised words read as X, permitting plain RAM inference.

Structure
REQ-022 SHALL place default DATA_WIDTH, ADDR_WIDTH and a DEPTH constant (2**ADDR_WIDTH) in shared package data_memory_pkg.
REQ-023 SHALL be a single module; no sub-module is required.

Verification
REQ-024 SHALL check reset: write 32'hFFFFFFFF to addresses 0 and 255, pulse rst one cycle -> readData = 0 at both (macro defined); both retained (macro undefined).
REQ-025 SHALL check write/read: rst=0, address=0, writeEnable=1, writeData=32'hAABBCCDD one edge, then writeData=32'h11223344 next edge, writeEnable=0 -> readData = 32'h11223344.
REQ-026 SHALL check no-write: writeEnable=0, writeData=32'hDEADBEEF over 5 edges at address 0 -> readData stays 32'h11223344.
REQ-027 SHALL check reset priority: rst=1, writeEnable=1, address=3, writeData=32'h12345678 -> readData at 3 = 0 after the edge (macro defined).
REQ-028 SHALL check boundary and isolation: write 32'hA5A5A5A5 to 255 and 32'h5A5A5A5A to 0 -> each reads back its own value; address 1 unaffected.
REQ-029 SHALL check read-during-write: address=7 holding 32'h1, write 32'h2 -> readData = 32'h1 before the edge, 32'h2 after.
